// File: rtl/axi_lite_regbank_if.sv
// -----------------------------------------------------------------------------
// axi_lite_regbank_if
//   Bundle of the AXI4-Lite slave channel signals used by axi_lite_regbank.
//   Signal names follow the usual S_AXI_* naming so the bus reads like a
//   standard AXI4-Lite slave port.
//
//   Parameters
//     DATA_WIDTH : bus data width (32 or 64)
//     ADDR_WIDTH : byte-address width
//
//   Modports
//     master : drives AW/W/AR payload + valids, BREADY, RREADY
//     slave  : drives AWREADY/WREADY/ARREADY, B and R channels
// -----------------------------------------------------------------------------
interface axi_lite_regbank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  // Write address channel
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  // Write data channel
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  // Write response channel
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  // Read address channel
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  // Read data channel
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// -----------------------------------------------------------------------------
// axi_lite_regbank
//   AXI4-Lite slave exposing C_NUM_REGS registers of C_S_AXI_DATA_WIDTH bits.
//   Registers flagged in C_RO_MASK are read-only and read back STATUS_IN.
//   Write and read paths are independent single-outstanding FSMs.
//
//   Ports
//     ACLK      : clock, rising edge
//     ARESETN   : synchronous active-low reset
//     s_axi     : AXI4-Lite slave bus (axi_lite_regbank_if.slave)
//     REG_OUT   : all register values, register i at slice i (read-only = 0)
//     STATUS_IN : read-only sources, slice i used when C_RO_MASK[i] = 1
//     WR_PULSE  : one-cycle strobe per register after a successful write
// -----------------------------------------------------------------------------
module axi_lite_regbank #(
  parameter int                    C_S_AXI_DATA_WIDTH = 32,
  parameter int                    C_S_AXI_ADDR_WIDTH = 6,
  parameter int                    C_NUM_REGS         = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  axi_lite_regbank_if.slave                      s_axi,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REG_OUT,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] STATUS_IN,
  output logic [C_NUM_REGS-1:0]                  WR_PULSE
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(DW / 8);
  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  // Low during reset and for the reset-release edge itself, so no ready
  // asserts before the first cycle after ARESETN=1 is sampled.
  logic ready_en_q;

  // Write capture: AW and W are held independently until both are present.
  logic             aw_held_q, w_held_q;
  logic [IDX_W-1:0] aw_idx_q;
  logic [DW-1:0]    wdata_q;
  logic [SW-1:0]    wstrb_q;
  logic [1:0]       bresp_q;

  logic [DW-1:0]         regs_q [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] wr_pulse_q;

  logic [DW-1:0] rdata_q;
  logic [1:0]    rresp_q;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [C_NUM_REGS-1:0] wr_sel;
  logic                  wr_ok;
  logic [IDX_W-1:0]      ar_idx;
  logic                  rd_hit;
  logic [DW-1:0]         rd_val;

  // Protection bits and sub-word address bits have no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[ADDR_LSB-1:0],
                           s_axi.S_AXI_ARADDR[ADDR_LSB-1:0], STATUS_IN};

  assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs   = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
  assign b_hs   = s_axi.S_AXI_BVALID  && s_axi.S_AXI_BREADY;
  assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign r_hs   = s_axi.S_AXI_RVALID  && s_axi.S_AXI_RREADY;
  assign commit = (wstate_q == W_IDLE) && aw_held_q && w_held_q;

  // Index decode is done at full index width: an out-of-range index simply
  // matches no register, so wr_sel stays zero and the write is rejected.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_sel = '0;
    for (int i = 0; i < C_NUM_REGS; i++) wr_sel[i] = (aw_idx_q == IDX_W'(i));
  end

  assign wr_ok  = |(wr_sel & ~C_RO_MASK);
  assign ar_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_hit = 1'b1;
        rd_val = C_RO_MASK[i] ? STATUS_IN[i*DW +: DW] : regs_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // pre-edge values; this is also what makes a read on the commit edge
    // return the old register contents.
    if (!ARESETN) begin
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      ready_en_q <= 1'b0;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      ready_en_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wstate_d = wstate_q;
    unique case (wstate_q)
      W_IDLE: if (commit) wstate_d = W_RESP;
      W_RESP: if (b_hs)   wstate_d = W_IDLE;
      default:            wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      R_IDLE: if (ar_hs) rstate_d = R_DATA;
      R_DATA: if (r_hs)  rstate_d = R_IDLE;
      default:           rstate_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    s_axi.S_AXI_AWREADY = ready_en_q && (wstate_q == W_IDLE) && !aw_held_q;
    s_axi.S_AXI_WREADY  = ready_en_q && (wstate_q == W_IDLE) && !w_held_q;
    s_axi.S_AXI_BVALID  = (wstate_q == W_RESP);
    s_axi.S_AXI_ARREADY = ready_en_q && (rstate_q == R_IDLE);
    s_axi.S_AXI_RVALID  = (rstate_q == R_DATA);
  end

  assign s_axi.S_AXI_BRESP = bresp_q;
  assign s_axi.S_AXI_RDATA = rdata_q;
  assign s_axi.S_AXI_RRESP = rresp_q;

  // ---------------------------------------------------------------------------
  // Datapath: capture, commit, read sample
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      // NOTE: the register array is reset explicitly; software relies on
      // known zeros, so it is built from flops rather than an unreset RAM.
      for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_pulse_q <= '0;

      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axi.S_AXI_WDATA;
        wstrb_q  <= s_axi.S_AXI_WSTRB;
      end

      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) wr_pulse_q <= wr_sel;
        // Read-only registers are never written, so they stay at zero.
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (wr_sel[i] && !C_RO_MASK[i]) begin
            for (int b = 0; b < SW; b++) begin
              if (wstrb_q[b]) regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
        end
      end

      if (ar_hs) begin
        rdata_q <= rd_hit ? rd_val : '0;
        rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_comb begin
    REG_OUT = '0;
    for (int i = 0; i < C_NUM_REGS; i++) REG_OUT[i*DW +: DW] = regs_q[i];
  end

  assign WR_PULSE = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_regbank
//   Directed bench for axi_lite_regbank. dut_a: 32-bit, 8 regs, reg 7 read-only.
//   dut_b: 64-bit, 4 regs. One shared set of bus drivers; 'sel' picks the DUT.
// -----------------------------------------------------------------------------
module tb_axi_lite_regbank;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel;
  logic [5:0]  awaddr, araddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;

  logic [255:0] reg_out_a, status_a;
  logic [7:0]   pulse_a;
  logic [255:0] reg_out_b, status_b;
  logic [3:0]   pulse_b;

  axi_lite_regbank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) ia ();
  axi_lite_regbank_if #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) ib ();

  assign ia.S_AXI_AWADDR  = awaddr;
  assign ia.S_AXI_AWPROT  = 3'b000;
  assign ia.S_AXI_AWVALID = awvalid && !sel;
  assign ia.S_AXI_WDATA   = wdata[31:0];
  assign ia.S_AXI_WSTRB   = wstrb[3:0];
  assign ia.S_AXI_WVALID  = wvalid && !sel;
  assign ia.S_AXI_BREADY  = bready && !sel;
  assign ia.S_AXI_ARADDR  = araddr;
  assign ia.S_AXI_ARPROT  = 3'b000;
  assign ia.S_AXI_ARVALID = arvalid && !sel;
  assign ia.S_AXI_RREADY  = rready && !sel;

  assign ib.S_AXI_AWADDR  = awaddr;
  assign ib.S_AXI_AWPROT  = 3'b000;
  assign ib.S_AXI_AWVALID = awvalid && sel;
  assign ib.S_AXI_WDATA   = wdata;
  assign ib.S_AXI_WSTRB   = wstrb;
  assign ib.S_AXI_WVALID  = wvalid && sel;
  assign ib.S_AXI_BREADY  = bready && sel;
  assign ib.S_AXI_ARADDR  = araddr;
  assign ib.S_AXI_ARPROT  = 3'b000;
  assign ib.S_AXI_ARVALID = arvalid && sel;
  assign ib.S_AXI_RREADY  = rready && sel;

  assign awready = sel ? ib.S_AXI_AWREADY : ia.S_AXI_AWREADY;
  assign wready  = sel ? ib.S_AXI_WREADY  : ia.S_AXI_WREADY;
  assign bvalid  = sel ? ib.S_AXI_BVALID  : ia.S_AXI_BVALID;
  assign bresp   = sel ? ib.S_AXI_BRESP   : ia.S_AXI_BRESP;
  assign arready = sel ? ib.S_AXI_ARREADY : ia.S_AXI_ARREADY;
  assign rvalid  = sel ? ib.S_AXI_RVALID  : ia.S_AXI_RVALID;
  assign rresp   = sel ? ib.S_AXI_RRESP   : ia.S_AXI_RRESP;
  assign rdata   = sel ? ib.S_AXI_RDATA   : {32'h0, ia.S_AXI_RDATA};

  // Slice 7 is the read-only source; the other slices hold a pattern that
  // must never leak into a read of a writable register.
  assign status_a = {32'hDEAD_BEEF, {7{32'hCAFE_0000}}};
  assign status_b = '1;

  axi_lite_regbank #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6),
    .C_NUM_REGS(8), .C_RO_MASK(8'h80)
  ) dut_a (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(ia),
    .REG_OUT(reg_out_a), .STATUS_IN(status_a), .WR_PULSE(pulse_a)
  );

  axi_lite_regbank #(
    .C_S_AXI_DATA_WIDTH(64), .C_S_AXI_ADDR_WIDTH(6),
    .C_NUM_REGS(4), .C_RO_MASK(4'h0)
  ) dut_b (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(ib),
    .REG_OUT(reg_out_b[255:0]), .STATUS_IN(status_b[255:0]), .WR_PULSE(pulse_b)
  );

  // Counts the cycles each WR_PULSE bit of dut_a is seen high.
  int pulse_cnt [8] = '{default: 0};
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) if (pulse_a[i]) pulse_cnt[i]++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input string tag, input logic [5:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, b_done;
    aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0; resp = 2'bxx;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready)   w_done  = 1'b1;
      @(negedge clk);
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 0; n < 20 && !b_done; n++) begin
      if (bvalid) begin resp = bresp; b_done = 1'b1; end
      @(negedge clk);
    end
    bready = 1'b0;
    check({tag, " handshake"}, {61'h0, aw_done, w_done, b_done}, 64'h7);
  endtask

  task automatic axi_read(input string tag, input logic [5:0] addr, output logic [63:0] data,
                          output logic [1:0] resp, output int lat);
    bit ar_done, r_done;
    ar_done = 1'b0; r_done = 1'b0; data = 'x; resp = 2'bxx; lat = -1;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int n = 0; n < 20 && !ar_done; n++) begin
      if (arready) ar_done = 1'b1;
      @(negedge clk);
    end
    arvalid = 1'b0;
    for (int n = 0; n < 20 && !r_done; n++) begin
      if (rvalid) begin data = rdata; resp = rresp; r_done = 1'b1; lat = n; end
      @(negedge clk);
    end
    rready = 1'b0;
    check({tag, " handshake"}, {62'h0, ar_done, r_done}, 64'h3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [63:0] data;
    int          lat;
    int          bv_cycles, extra_rdy;
    bit          got;

    sel = 1'b0; rst_n = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst awready", awready, 0);
    check("rst wready", wready, 0);
    check("rst arready", arready, 0);
    check("rst bvalid/rvalid", {bvalid, rvalid}, 0);
    check("rst bresp/rresp/rdata", {bresp, rresp, rdata[31:0]}, 0);
    check("rst reg_out", reg_out_a, 0);
    check("rst wr_pulse", pulse_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst readys", {awready, wready, arready}, 3'b111);

    // ---- basic writes and readback ----
    for (int i = 0; i < 4; i++) begin
      axi_write($sformatf("wr reg%0d", i), 6'(i * 4), 64'(i + 1), 8'h0F, resp);
      check($sformatf("bresp reg%0d", i), resp, OKAY);
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("pulse count reg%0d", i), pulse_cnt[i], (i < 4) ? 1 : 0);
    for (int i = 0; i < 4; i++) begin
      axi_read($sformatf("rd reg%0d", i), 6'(i * 4), data, resp, lat);
      check($sformatf("rdata reg%0d", i), data, 64'(i + 1));
      check($sformatf("rresp reg%0d", i), resp, OKAY);
      if (i == 0) check("read latency", 64'(lat), 0);
    end

    // ---- byte strobes ----
    axi_write("wr reg2 full", 6'h08, 64'hAABB_CCDD, 8'h0F, resp);
    axi_write("wr reg2 strb", 6'h08, 64'h1122_3344, 8'h05, resp);
    check("bresp strb", resp, OKAY);
    axi_read("rd reg2", 6'h08, data, resp, lat);
    check("rdata strb merge", data, 64'hAA22_CC44);
    check("reg_out slice2", reg_out_a[64 +: 32], 32'hAA22_CC44);
    axi_read("rd reg2 low bits", 6'h0B, data, resp, lat);
    check("rdata addr low bits ignored", data, 64'hAA22_CC44);
    axi_write("wr reg1 strb0", 6'h04, 64'hFFFF_FFFF, 8'h00, resp);
    check("pulse on strb0", pulse_cnt[1], 2);
    check("reg1 unchanged strb0", reg_out_a[32 +: 32], 32'h2);

    // ---- W 3 cycles ahead of AW, BREADY stalled ----
    @(negedge clk);
    awaddr = 6'h0C; wdata = 64'h55; wstrb = 8'h0F; wvalid = 1'b1; bready = 1'b0;
    check("early w wready", wready, 1);
    @(negedge clk);
    wvalid = 1'b0;
    check("w held blocks wready", wready, 0);
    check("aw still ready", awready, 1);
    repeat (2) @(negedge clk);
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      if (bvalid) got = 1'b1;
      else @(negedge clk);
    end
    check("stall bvalid seen", got, 1);
    awaddr = 6'h10; wdata = 64'h77; awvalid = 1'b1; wvalid = 1'b1;
    bv_cycles = 0; extra_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      if (bvalid) bv_cycles++;
      if (awready || wready) extra_rdy++;
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid held while stalled", bv_cycles, 4);
    check("no accept during W_RESP", extra_rdy, 0);
    check("bresp stall", bresp, OKAY);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid drops after B hs", bvalid, 0);
    check("awready after B hs", awready, 1);
    check("stall single commit", pulse_cnt[3], 2);
    check("stall reg3 value", reg_out_a[96 +: 32], 32'h55);
    check("stall reg4 untouched", reg_out_a[128 +: 32], 32'h0);

    // ---- AR on the commit edge returns pre-write value ----
    @(negedge clk);
    awaddr = 6'h00; wdata = 64'h99; wstrb = 8'h0F; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b1; araddr = 6'h00;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; rready = 1'b1;
    check("arready at commit", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    check("same-edge rvalid", rvalid, 1);
    check("same-edge pre-write rdata", rdata, 64'h1);
    check("same-edge reg_out new", reg_out_a[31:0], 32'h99);
    check("same-edge bvalid", bvalid, 1);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;

    // ---- read-only and out-of-range ----
    axi_write("wr ro reg7", 6'h1C, 64'h1, 8'h0F, resp);
    check("bresp ro", resp, SLVERR);
    check("no pulse ro", pulse_cnt[7], 0);
    check("reg_out ro slice", reg_out_a[224 +: 32], 32'h0);
    axi_read("rd ro reg7", 6'h1C, data, resp, lat);
    check("rdata ro status", data, 64'hDEAD_BEEF);
    check("rresp ro", resp, OKAY);
    axi_read("rd oor 0x20", 6'h20, data, resp, lat);
    check("rdata oor", data, 64'h0);
    check("rresp oor", resp, SLVERR);
    axi_read("rd oor 0x3C", 6'h3C, data, resp, lat);
    check("rresp oor top", resp, SLVERR);
    axi_write("wr oor 0x20", 6'h20, 64'h5, 8'h0F, resp);
    check("bresp oor", resp, SLVERR);

    // ---- 64-bit instance ----
    sel = 1'b1;
    axi_write("wr64", 6'h08, 64'h0123_4567_89AB_CDEF, 8'hFF, resp);
    check("bresp 64", resp, OKAY);
    axi_read("rd64 0x08", 6'h08, data, resp, lat);
    check("rdata64 0x08", data, 64'h0123_4567_89AB_CDEF);
    axi_read("rd64 0x0C", 6'h0C, data, resp, lat);
    check("rdata64 0x0C", data, 64'h0123_4567_89AB_CDEF);
    check("rresp64 0x0C", resp, OKAY);
    check("reg_out64 slice1", reg_out_b[64 +: 64], 64'h0123_4567_89AB_CDEF);
    sel = 1'b0;

    // ---- reset while AW/W held ----
    @(negedge clk);
    awaddr = 6'h10; wdata = 64'h1234; wstrb = 8'h0F; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("mid-rst awready", awready, 0);
    check("mid-rst bvalid", bvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release awready", awready, 1);
    bv_cycles = 0;
    for (int k = 0; k < 5; k++) begin
      if (bvalid) bv_cycles++;
      @(negedge clk);
    end
    bready = 1'b0;
    check("abandoned no bvalid", bv_cycles, 0);
    check("abandoned no pulse", pulse_cnt[4], 0);
    check("abandoned reg4 zero", reg_out_a[128 +: 32], 32'h0);
    check("reset cleared regs", reg_out_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_regbank.md
AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 SHALL provide parameter C_S_AXI_DATA_WIDTH, default 32, register and bus data width; legal values 32 or 64.
REQ-002 SHALL provide parameter C_S_AXI_ADDR_WIDTH, default 6, byte-address width.
REQ-003 SHALL provide parameter C_NUM_REGS, default 8, register count; legal range 1..2**(C_S_AXI_ADDR_WIDTH-ADDR_LSB).
REQ-004 SHALL provide parameter C_RO_MASK, default 0, C_NUM_REGS bits; bit i=1 makes register i read-only, sourced from STATUS_IN.
REQ-005 SHALL define ADDR_LSB = log2(C_S_AXI_DATA_WIDTH/8); word index = AWADDR/ARADDR >> ADDR_LSB.
REQ-006 SHALL have ports:
  ACLK  in  1  sole clock, rising edge
  ARESETN  in  1  reset, synchronous, active-low
  S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
  S_AXI_AWPROT  in  3  ignored
  S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
  S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data
  S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables
  S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
  S_AXI_BRESP  out  2  write response
  S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
  S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
  S_AXI_ARPROT  in  3  ignored
  S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
  S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data
  S_AXI_RRESP  out  2  read response
  S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
  REG_OUT  out  C_NUM_REGS*C_S_AXI_DATA_WIDTH  all register values, register i at slice i
  STATUS_IN  in  C_NUM_REGS*C_S_AXI_DATA_WIDTH  read-only sources, slice i used when C_RO_MASK[i]=1
  WR_PULSE  out  C_NUM_REGS  one-cycle strobe per register on committed write

Function
REQ-007 Write path SHALL use FSM W_IDLE -> W_RESP; AWREADY high in W_IDLE until AW captured, WREADY high in W_IDLE until W captured; AW and W accepted in either order or same cycle, each held until both present.
REQ-008 On the edge where both AW and W are held, SHALL commit: byte lane b of register idx updated iff WSTRB[b]=1; state -> W_RESP; BVALID high next cycle.
REQ-009 In W_RESP, BVALID SHALL stay high and BRESP stable until BREADY; AWREADY/WREADY low; on BVALID&&BREADY return to W_IDLE, ready to accept next cycle.
REQ-010 BRESP SHALL be OKAY (00) for in-range writable index; SLVERR (10) for idx >= C_NUM_REGS or C_RO_MASK[idx]=1, with no register change and no WR_PULSE.
REQ-011 WR_PULSE[idx] SHALL be high exactly the one cycle after an OKAY commit, even if WSTRB=0.
REQ-012 Read path SHALL use FSM R_IDLE -> R_DATA; ARREADY high in R_IDLE; on AR handshake RDATA/RRESP registered, RVALID high next cycle (latency 1).
REQ-013 RVALID, RDATA, RRESP SHALL hold stable until RREADY; ARREADY low in R_DATA; return to R_IDLE on handshake.
REQ-014 RDATA SHALL be register value (or STATUS_IN slice if read-only) sampled at AR handshake edge; RRESP OKAY; idx >= C_NUM_REGS SHALL return RDATA 0, RRESP SLVERR.
REQ-015 Read and write paths SHALL be independent; AR handshake on the same edge as a write commit to same index SHALL return the pre-write value.
REQ-016 Address bits below ADDR_LSB SHALL be ignored; index computed at full width, so upper address bits set yield out-of-range.
REQ-017 REG_OUT SHALL reflect committed values combinationally from registers (update visible the cycle after commit); read-only slices of REG_OUT SHALL be 0.

Reset
REQ-018 While ARESETN=0 at a rising edge: all registers 0, both FSMs idle, AWREADY/WREADY/ARREADY 0, BVALID/RVALID 0, BRESP/RRESP 00, RDATA 0, WR_PULSE 0, captured AW/W discarded.
REQ-019 Reset mid-transaction SHALL abandon it with no commit; ready signals SHALL assert the first cycle after ARESETN=1 is sampled.

Verification
REQ-020 Defaults, write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back -> each BRESP/RRESP OKAY, RDATA matches, WR_PULSE[0..3] one cycle each.
REQ-021 Reg 2 = 0xAABBCCDD, write 0x11223344 WSTRB=0b0101 -> readback 0xAA22CC44, REG_OUT slice 2 same.
REQ-022 W presented 3 cycles before AW; BREADY held low 4 cycles -> one commit, BVALID held 4 cycles, no second AW/W accepted meanwhile.
REQ-023 C_RO_MASK=0x80, STATUS_IN slice 7 = 0xDEADBEEF; write 0x1 to 0x1C -> BRESP SLVERR, no WR_PULSE; read 0x1C -> 0xDEADBEEF OKAY; read 0x20 -> 0, SLVERR.
REQ-024 C_S_AXI_DATA_WIDTH=64, C_NUM_REGS=4: write 0x0123456789ABCDEF to 0x08, read 0x08 and 0x0C -> both return 0x0123456789ABCDEF.
REQ-025 ARESETN low one cycle after AW/W captured -> no commit, reg value stays 0, BVALID never asserts, AWREADY high first cycle after release.
